// File: rtl/i2s_pkg.sv
// i2s_pkg: shared frame geometry for the I2S master-mode blocks.
// Positions below describe the default slot; users rebase them to their SLOT_W.
package i2s_pkg;

  localparam int WORD_W_DEF = 24;
  localparam int SLOT_W_DEF = 32;

  localparam int L_MSB_POS  = 0;
  localparam int R_MSB_POS  = SLOT_W_DEF;
  localparam int LR_SWITCH  = SLOT_W_DEF - 1;
  localparam int FRAME_LEN  = 2 * SLOT_W_DEF;

  function automatic int frame_bit_cnt_w(input int slot_w);
    return $clog2(2 * slot_w);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: BCK/LRCK generation and frame-position strobes for an I2S master.
// Reusable by a slave-mode receiver; all state idles while enable is low.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int SLOT_W  = SLOT_W_DEF,
  parameter int BCK_DIV = 4,
  localparam int CW     = frame_bit_cnt_w(SLOT_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          bck,
  output logic          lrck,
  output logic          fall,
  output logic          frame_start,
  output logic [CW-1:0] bit_nxt
);

  localparam int DW    = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int SHIFT = SLOT_W - SLOT_W_DEF;
  localparam int FL    = FRAME_LEN + 2 * SHIFT;
  localparam int LR_SW = LR_SWITCH + SHIFT;

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] bit_q, bit_d;
  logic          bck_q, bck_d;
  logic          lrck_q, lrck_d;
  logic          wrap;
  logic          last;

  always_comb begin
    wrap        = (div_q == DW'(BCK_DIV - 1));
    last        = (bit_q == CW'(FL - 1));
    fall        = enable && wrap && bck_q;
    frame_start = fall && last;
    bit_nxt     = last ? '0 : bit_q + CW'(1);
    div_d       = wrap ? '0 : div_q + DW'(1);
    bck_d       = wrap ? ~bck_q : bck_q;
    bit_d       = fall ? bit_nxt : bit_q;
    lrck_d      = lrck_q;
    if (fall) begin
      lrck_d = (int'(bit_nxt) >= LR_SW) && (int'(bit_nxt) <= FL - 2);
    end
    if (!enable) begin
      div_d  = '0;
      bck_d  = 1'b0;
      bit_d  = CW'(FL - 1);
      lrck_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q  <= '0;
      bck_q  <= 1'b0;
      bit_q  <= CW'(FL - 1);
      lrck_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bck_q  <= bck_d;
      bit_q  <= bit_d;
      lrck_q <= lrck_d;
    end
  end

  assign bck  = bck_q;
  assign lrck = lrck_q;

endmodule

// File: rtl/i2s_xmit.sv
// i2s_xmit: master-mode I2S transmitter with a one-pair holding register.
// Define I2S_XMIT_REPEAT_EN to retransmit the last pair on underrun.
module i2s_xmit
  import i2s_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int SLOT_W  = SLOT_W_DEF,
  parameter int BCK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [WORD_W-1:0] s_ldata,
  input  logic [WORD_W-1:0] s_rdata,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              bck,
  output logic              lrck,
  output logic              sdata,
  output logic              underrun
);

  localparam int CW    = frame_bit_cnt_w(SLOT_W);
  localparam int R_POS = R_MSB_POS + (SLOT_W - SLOT_W_DEF);

  logic          fall;
  logic          frame_start;
  logic [CW-1:0] bit_nxt;

  logic [WORD_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [WORD_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic              hold_full_q, hold_full_d;
  logic              s_ready_q, s_ready_d;
  logic              sdata_q, sdata_d;
  logic              underrun_q, underrun_d;
  logic [WORD_W-1:0] sh_l, sh_r;
  logic              hs;
  int                pos;

  i2s_clkgen #(
    .SLOT_W  (SLOT_W),
    .BCK_DIV (BCK_DIV)
  ) u_clkgen (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bck         (bck),
    .lrck        (lrck),
    .fall        (fall),
    .frame_start (frame_start),
    .bit_nxt     (bit_nxt)
  );

  always_comb begin
    hs          = s_valid && s_ready_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    frame_l_d   = frame_l_q;
    frame_r_d   = frame_r_q;
    underrun_d  = 1'b0;
    if (frame_start) begin
      if (hold_full_q) begin
        frame_l_d   = hold_l_q;
        frame_r_d   = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
`ifndef I2S_XMIT_REPEAT_EN
        frame_l_d  = '0;
        frame_r_d  = '0;
`endif
      end
    end
    // a pair offered on an empty-hold load still fills the hold
    if (hs) begin
      hold_l_d    = s_ldata;
      hold_r_d    = s_rdata;
      hold_full_d = 1'b1;
    end
    s_ready_d = !hold_full_d;

    pos     = int'(bit_nxt);
    sh_l    = '0;
    sh_r    = '0;
    sdata_d = sdata_q;
    if (fall) begin
      sdata_d = 1'b0;
      if (pos < L_MSB_POS + WORD_W) begin
        sh_l    = frame_l_d << (pos - L_MSB_POS);
        sdata_d = sh_l[WORD_W-1];
      end else if (pos >= R_POS && pos < R_POS + WORD_W) begin
        sh_r    = frame_r_d << (pos - R_POS);
        sdata_d = sh_r[WORD_W-1];
      end
    end
    if (!enable) begin
      sdata_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      frame_l_q   <= '0;
      frame_r_q   <= '0;
      hold_full_q <= 1'b0;
      s_ready_q   <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      frame_l_q   <= frame_l_d;
      frame_r_q   <= frame_r_d;
      hold_full_q <= hold_full_d;
      s_ready_q   <= s_ready_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;

endmodule
